mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DEFAULT_LAST, 1'b1, round-robin pointer value after reset (1 = port B granted last, so port A wins the first tie).
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 read_a  in  1  port A (instruction) read request; held until resp_a.
REQ-005 address_a  in  32  port A byte address.
REQ-006 resp_a  out  1  port A completion pulse.
REQ-007 rdata_a  out  32  port A read data, valid while resp_a=1.
REQ-008 read_b  in  1  port B (data) read request; held until resp_b.
REQ-009 write  in  1  port B write request; held until resp_b.
REQ-010 wmask  in  4  port B byte-write enables.
REQ-011 address_b  in  32  port B byte address.
REQ-012 wdata  in  32  port B write data.
REQ-013 resp_b  out  1  port B completion pulse.
REQ-014 rdata_b  out  32  port B read data, valid while resp_b=1.
REQ-015 mem_read, mem_write  out  1 each  single-port memory requests.
REQ-016 mem_wmask  out  4; mem_address  out  32; mem_wdata  out  32; downstream request fields.
REQ-017 mem_resp  in  1; mem_rdata  in  32; downstream completion and read data.
REQ-018 proto_err  out  1  sticky flag for a simultaneous read_b and write.

Function
REQ-019 FSM states are IDLE, BUSY_A, BUSY_B and DONE; every output is driven from registers.
REQ-020 IDLE, no request: stay IDLE; all mem_* outputs and resp_* outputs are 0.
REQ-021 IDLE, exactly one port requesting: at the next edge, latch that port's fields into the mem_* registers and enter BUSY_A or BUSY_B.
REQ-022 IDLE, both ports requesting: grant the port not granted last (round-robin), then update the last-grant register.
REQ-023 BUSY_x: hold the mem_* outputs constant until mem_resp=1 is sampled; requester inputs are ignored.
REQ-024 mem_resp sampled in BUSY_x: at that edge, clear the mem_* outputs, capture mem_rdata into rdata_x, set resp_x=1 for exactly one cycle, and enter DONE.
REQ-025 DONE: unconditional return to IDLE; no grant is made in DONE, so a requester's stale request is never re-served.
REQ-026 Latency: request seen at edge N gives mem request in cycle N..; mem_resp at edge M gives resp_x in cycle M..M+1; the earliest next grant is edge M+2.
REQ-027 mem_resp in IDLE or DONE is ignored.
REQ-028 Port B with read_b=1 and write=1 at grant: perform the write (mem_write=1, mem_read=0) and set proto_err=1, which stays set until reset.
REQ-029 Port A never drives mem_write; for port A, mem_wmask=0 and mem_wdata=0.
REQ-030 A requester that drops its request mid-transaction does not abort it; the downstream access completes and resp_x still pulses.
REQ-031 For a port B write, rdata_b=mem_rdata as captured; its value is don't-care to the requester.

Reset
REQ-032 rst=1 asynchronously forces IDLE, zeroes all outputs including proto_err, and sets last-grant to DEFAULT_LAST.
REQ-033 Reset during BUSY_x abandons the downstream access; a mem_resp arriving after reset is dropped per REQ-027.

Structure
REQ-034 The enum arb_state_t {IDLE, BUSY_A, BUSY_B, DONE} is defined in shared package rv32i_types.
REQ-035 The block is a single module with no sub-module; the round-robin pointer is one flip-flop.

Verification
REQ-036 Single A read: read_a=1, address_a=0x60, memory responds after 3 cycles with 0x00000013 -> mem_read=1 with mem_address=0x60 held for 3 cycles, then resp_a=1 for one cycle with rdata_a=0x00000013.
REQ-037 Simultaneous requests after reset: read_a=1 and read_b=1 at cycle 0 -> port A is served first, then port B; a second simultaneous pair is served B first.
REQ-038 B write: write=1, wmask=4'b0011, address_b=0x100, wdata=0xDEADBEEF -> mem_write=1 with identical fields, resp_b pulses once, mem_read stays 0.
REQ-039 Protocol error: read_b=1 and write=1 -> write performed, proto_err=1 that stays 1 across later transactions until rst.
REQ-040 Reset mid-access: rst pulses in BUSY_B, then mem_resp=1 arrives -> outputs go 0 immediately and resp_b never asserts.
REQ-041 Back-to-back A reads held continuously: one resp_a per access, with at least one DONE cycle between downstream requests.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared type definitions for the memory arbiter.
//
// Contents:
//   arb_state_t  - arbiter FSM states (IDLE, BUSY_A, BUSY_B, DONE)
//   mem_req_t    - the downstream request fields, kept together as one struct
//   MEM_REQ_NONE - an all-zero request, used whenever the memory is left alone
//   port_a_req() - builds the downstream request for an instruction read
//   port_b_req() - builds the downstream request for a data read or write
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [3:0]  wmask;
    logic [31:0] address;
    logic [31:0] wdata;
  } mem_req_t;

  localparam mem_req_t MEM_REQ_NONE = '0;

  // The instruction port can only read, so the write fields stay zero.
  function automatic mem_req_t port_a_req(input logic [31:0] address);
    mem_req_t r;
    r         = MEM_REQ_NONE;
    r.read    = 1'b1;
    r.address = address;
    return r;
  endfunction

  // When the data port raises read and write together, the write is carried
  // out and the read is dropped. For a plain read the write fields are zero.
  function automatic mem_req_t port_b_req(input logic        rd,
                                          input logic        wr,
                                          input logic [3:0]  wmask,
                                          input logic [31:0] address,
                                          input logic [31:0] wdata);
    mem_req_t r;
    r         = MEM_REQ_NONE;
    r.read    = rd & ~wr;
    r.write   = wr;
    r.wmask   = wr ? wmask : 4'b0000;
    r.address = address;
    r.wdata   = wr ? wdata : 32'h0000_0000;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port memory.
//
// Port A (instruction fetch) may only read. Port B (data) may read or write.
// One access is in flight at a time. When both ports ask at once, the port
// that was not granted last in a tie wins. Each finished access is followed
// by a one-cycle DONE state, so a request that is still held after its
// response is never served a second time by mistake.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   read_a, address_a             port A request (held until resp_a)
//   resp_a, rdata_a               port A completion pulse and read data
//   read_b, write, wmask,
//   address_b, wdata              port B request (held until resp_b)
//   resp_b, rdata_b               port B completion pulse and read data
//   mem_read, mem_write,
//   mem_wmask, mem_address,
//   mem_wdata                     downstream request, held until mem_resp
//   mem_resp, mem_rdata           downstream completion and read data
//   proto_err                     sticky: port B asked to read and write at once
//
// Parameter:
//   DEFAULT_LAST  tie-break pointer after reset (1 = port B went last, so
//                 port A wins the first tie)
module mem_arbiter
  import rv32i_types::*;
#(
  parameter logic DEFAULT_LAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        read_a,
  input  logic [31:0] address_a,
  output logic        resp_a,
  output logic [31:0] rdata_a,

  input  logic        read_b,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] address_b,
  input  logic [31:0] wdata,
  output logic        resp_b,
  output logic [31:0] rdata_b,

  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,

  output logic        proto_err
);

  arb_state_t  state_q,     state_d;
  logic        last_q,      last_d;
  mem_req_t    mem_req_q,   mem_req_d;
  logic        resp_a_q,    resp_a_d;
  logic        resp_b_q,    resp_b_d;
  logic [31:0] rdata_a_q,   rdata_a_d;
  logic [31:0] rdata_b_q,   rdata_b_d;
  logic        proto_err_q, proto_err_d;

  logic want_a;
  logic want_b;
  logic grant_a;
  logic grant_b;

  // Grant decision. It only matters in IDLE. In a tie, last_q says who won
  // the previous tie (1 = port B), and the other port gets the grant. A port
  // that asks alone does not move the pointer.
  always_comb begin
    want_a  = read_a;
    want_b  = read_b | write;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (want_a && want_b) begin
      grant_a = last_q;
      grant_b = ~last_q;
    end else begin
      grant_a = want_a;
      grant_b = want_b;
    end
  end

  // Next-state logic for every register. The response pulses default to 0,
  // so each one lasts exactly the cycle after the downstream response.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    resp_a_d    = 1'b0;
    resp_b_d    = 1'b0;
    rdata_a_d   = rdata_a_q;
    rdata_b_d   = rdata_b_q;
    proto_err_d = proto_err_q;

    unique case (state_q)
      IDLE: begin
        mem_req_d = MEM_REQ_NONE;
        if (grant_a) begin
          mem_req_d = port_a_req(address_a);
          state_d   = BUSY_A;
        end else if (grant_b) begin
          mem_req_d   = port_b_req(read_b, write, wmask, address_b, wdata);
          proto_err_d = proto_err_q | (read_b & write);
          state_d     = BUSY_B;
        end
        if (want_a && want_b) begin
          last_d = grant_b;
        end
      end

      // While busy, the requester inputs are ignored. The downstream request
      // stays fixed until the memory answers.
      BUSY_A: begin
        if (mem_resp) begin
          mem_req_d = MEM_REQ_NONE;
          rdata_a_d = mem_rdata;
          resp_a_d  = 1'b1;
          state_d   = DONE;
        end
      end

      BUSY_B: begin
        if (mem_resp) begin
          mem_req_d = MEM_REQ_NONE;
          rdata_b_d = mem_rdata;
          resp_b_d  = 1'b1;
          state_d   = DONE;
        end
      end

      // One idle cycle after a response. The requester sees its resp pulse
      // here and can drop its request before the arbiter looks again.
      DONE: begin
        mem_req_d = MEM_REQ_NONE;
        state_d   = IDLE;
      end

      default: begin
        mem_req_d = MEM_REQ_NONE;
        state_d   = IDLE;
      end
    endcase
  end

  // All state and every output live in this one register bank. Reset drops
  // any access in flight, so a late mem_resp arrives in IDLE and is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= DEFAULT_LAST;
      mem_req_q   <= MEM_REQ_NONE;
      resp_a_q    <= 1'b0;
      resp_b_q    <= 1'b0;
      rdata_a_q   <= 32'h0000_0000;
      rdata_b_q   <= 32'h0000_0000;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      resp_a_q    <= resp_a_d;
      resp_b_q    <= resp_b_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign mem_read    = mem_req_q.read;
  assign mem_write   = mem_req_q.write;
  assign mem_wmask   = mem_req_q.wmask;
  assign mem_address = mem_req_q.address;
  assign mem_wdata   = mem_req_q.wdata;
  assign resp_a      = resp_a_q;
  assign resp_b      = resp_b_q;
  assign rdata_a     = rdata_a_q;
  assign rdata_b     = rdata_b_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
//
// A transaction-level model follows one access at a time. It tracks who owns
// the memory, the request fields that are showing, and a one-cycle pause after
// each completion. The DUT outputs are compared with the model on every falling
// edge. Directed sequences with literal expectations come first. A randomized
// phase with random requesters, a random memory responder and occasional
// resets follows.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_a = 1'b0;
  logic [31:0] address_a = '0;
  logic        resp_a;
  logic [31:0] rdata_a;
  logic        read_b = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  wmask = '0;
  logic [31:0] address_b = '0;
  logic [31:0] wdata = '0;
  logic        resp_b;
  logic [31:0] rdata_b;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        proto_err;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.DEFAULT_LAST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write(write), .wmask(wmask), .address_b(address_b),
    .wdata(wdata), .resp_b(resp_b), .rdata_b(rdata_b),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Reference model. owner: 0 = memory free, 1 = port A, 2 = port B.
  int          m_owner = 0;
  bit          m_pause = 1'b0;
  bit          m_last_b = 1'b1;
  bit          m_want_a, m_want_b;
  logic        m_read = 1'b0, m_write = 1'b0;
  logic [3:0]  m_wmask = '0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic        m_resp_a = 1'b0, m_resp_b = 1'b0, m_proto = 1'b0;
  logic [31:0] m_rdata_a = '0, m_rdata_b = '0;

  task automatic model_clear_req();
    m_read = 1'b0; m_write = 1'b0; m_wmask = '0; m_addr = '0; m_wdata = '0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = 0; m_pause = 1'b0; m_last_b = 1'b1;
      model_clear_req();
      m_resp_a = 1'b0; m_resp_b = 1'b0; m_proto = 1'b0;
      m_rdata_a = '0; m_rdata_b = '0;
    end else begin
      m_resp_a = 1'b0;
      m_resp_b = 1'b0;
      if (m_pause) begin
        m_pause = 1'b0;
      end else if (m_owner != 0) begin
        if (mem_resp) begin
          if (m_owner == 1) begin m_resp_a = 1'b1; m_rdata_a = mem_rdata; end
          else              begin m_resp_b = 1'b1; m_rdata_b = mem_rdata; end
          model_clear_req();
          m_owner = 0;
          m_pause = 1'b1;
        end
      end else begin
        m_want_a = read_a;
        m_want_b = read_b | write;
        if (m_want_a && m_want_b) begin
          m_owner  = m_last_b ? 1 : 2;
          m_last_b = (m_owner == 2);
        end else if (m_want_a) m_owner = 1;
        else if (m_want_b)     m_owner = 2;
        if (m_owner == 1) begin
          m_read = 1'b1; m_write = 1'b0; m_wmask = '0; m_addr = address_a; m_wdata = '0;
        end else if (m_owner == 2) begin
          m_write = write;
          m_read  = read_b && !write;
          m_wmask = write ? wmask : 4'b0;
          m_wdata = write ? wdata : 32'h0;
          m_addr  = address_b;
          if (read_b && write) m_proto = 1'b1;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare against the model on every falling edge while reset is released.
  always @(negedge clk) begin
    if (!rst) begin
      check_output("mem_read",    {31'b0, mem_read},  {31'b0, m_read});
      check_output("mem_write",   {31'b0, mem_write}, {31'b0, m_write});
      check_output("mem_wmask",   {28'b0, mem_wmask}, {28'b0, m_wmask});
      check_output("mem_address", mem_address,        m_addr);
      check_output("mem_wdata",   mem_wdata,          m_wdata);
      check_output("resp_a",      {31'b0, resp_a},    {31'b0, m_resp_a});
      check_output("resp_b",      {31'b0, resp_b},    {31'b0, m_resp_b});
      check_output("proto_err",   {31'b0, proto_err}, {31'b0, m_proto});
      if (m_resp_a) check_output("rdata_a", rdata_a, m_rdata_a);
      if (m_resp_b) check_output("rdata_b", rdata_b, m_rdata_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_idle();
    read_a = 1'b0; address_a = '0; read_b = 1'b0; write = 1'b0;
    wmask = '0; address_b = '0; wdata = '0; mem_resp = 1'b0; mem_rdata = '0;
  endtask

  task automatic apply_reset();
    apply_stimulus_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int resp_count;

  initial begin
    // Reset values
    apply_reset();
    check_output("reset mem_read",  {31'b0, mem_read},  32'd0);
    check_output("reset mem_write", {31'b0, mem_write}, 32'd0);
    check_output("reset resp_a",    {31'b0, resp_a},    32'd0);
    check_output("reset proto_err", {31'b0, proto_err}, 32'd0);

    // Single port A read, memory answers after three cycles
    read_a = 1'b1; address_a = 32'h60;
    tick();
    for (int i = 0; i < 3; i++) begin
      check_output("A read mem_read",    {31'b0, mem_read}, 32'd1);
      check_output("A read mem_address", mem_address,       32'h60);
      check_output("A read mem_write",   {31'b0, mem_write}, 32'd0);
      if (i < 2) tick();
    end
    mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
    tick();
    mem_resp = 1'b0; read_a = 1'b0;
    check_output("A read resp_a",   {31'b0, resp_a},   32'd1);
    check_output("A read rdata_a",  rdata_a,           32'h0000_0013);
    check_output("A read released", {31'b0, mem_read}, 32'd0);
    tick();
    check_output("A read resp_a pulse", {31'b0, resp_a}, 32'd0);

    // Tie after reset goes to A, then B; the next tie goes to B
    apply_reset();
    read_a = 1'b1; address_a = 32'h1000; read_b = 1'b1; address_b = 32'h2000;
    tick();
    check_output("tie1 address A", mem_address, 32'h1000);
    mem_resp = 1'b1; mem_rdata = 32'hA;
    tick();
    mem_resp = 1'b0; read_a = 1'b0;
    check_output("tie1 resp_a", {31'b0, resp_a}, 32'd1);
    tick();
    tick();
    check_output("tie1 then B", mem_address, 32'h2000);
    mem_resp = 1'b1; mem_rdata = 32'hB;
    tick();
    mem_resp = 1'b0;
    check_output("tie1 resp_b", {31'b0, resp_b}, 32'd1);
    read_a = 1'b1; address_a = 32'h3000; address_b = 32'h4000;
    tick();
    tick();
    check_output("tie2 B first", mem_address, 32'h4000);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0; read_b = 1'b0;
    tick();
    tick();
    check_output("tie2 then A", mem_address, 32'h3000);
    mem_resp = 1'b1;
    tick();
    apply_stimulus_idle();
    tick();

    // Port B write
    apply_reset();
    write = 1'b1; wmask = 4'b0011; address_b = 32'h100; wdata = 32'hDEAD_BEEF;
    tick();
    check_output("B write mem_write", {31'b0, mem_write}, 32'd1);
    check_output("B write mem_read",  {31'b0, mem_read},  32'd0);
    check_output("B write mem_wmask", {28'b0, mem_wmask}, 32'h3);
    check_output("B write address",   mem_address,        32'h100);
    check_output("B write wdata",     mem_wdata,          32'hDEAD_BEEF);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0; write = 1'b0;
    check_output("B write resp_b",    {31'b0, resp_b},    32'd1);
    check_output("B write proto_err", {31'b0, proto_err}, 32'd0);
    tick();

    // Read and write together: the write is done and proto_err sticks
    read_b = 1'b1; write = 1'b1; wmask = 4'hF; address_b = 32'h200; wdata = 32'h1234_5678;
    tick();
    check_output("proto mem_write", {31'b0, mem_write}, 32'd1);
    check_output("proto mem_read",  {31'b0, mem_read},  32'd0);
    check_output("proto flag",      {31'b0, proto_err}, 32'd1);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0; read_b = 1'b0; write = 1'b0;
    tick();
    read_a = 1'b1; address_a = 32'h40;
    tick();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0; read_a = 1'b0;
    check_output("proto sticky", {31'b0, proto_err}, 32'd1);
    tick();

    // Reset during BUSY_B, then a late mem_resp
    read_b = 1'b1; address_b = 32'h500;
    tick();
    check_output("busyB mem_read", {31'b0, mem_read}, 32'd1);
    rst = 1'b1; read_b = 1'b0;
    #1;
    check_output("rst clears mem_read",  {31'b0, mem_read},  32'd0);
    check_output("rst clears proto_err", {31'b0, proto_err}, 32'd0);
    rst = 1'b0;
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    check_output("late resp dropped", {31'b0, resp_b}, 32'd0);
    tick();
    check_output("late resp still dropped", {31'b0, resp_b}, 32'd0);

    // Back-to-back A reads with read_a held: a 3-cycle rhythm
    read_a = 1'b1; address_a = 32'h80;
    resp_count = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      mem_resp = mem_read;
      if (resp_a) resp_count++;
      if (resp_a && mem_read) check_output("no overlap", 32'd1, 32'd0);
    end
    check_output("back-to-back resp count", resp_count, 32'd4);
    apply_stimulus_idle();
    tick();

    // Randomized phase
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (read_a && resp_a) begin
        if ($urandom_range(1, 0) == 0) read_a = 1'b0;
        else address_a = $urandom;
      end else if (read_a && $urandom_range(15, 0) == 0) begin
        read_a = 1'b0;
      end else if (!read_a && $urandom_range(2, 0) == 0) begin
        read_a = 1'b1; address_a = $urandom;
      end
      if ((read_b || write) && resp_b) begin
        read_b = 1'b0; write = 1'b0;
      end else if (!(read_b || write) && $urandom_range(2, 0) == 0) begin
        case ($urandom_range(15, 0))
          0:       begin read_b = 1'b1; write = 1'b1; end
          1,2,3,4,5,6,7: begin read_b = 1'b1; write = 1'b0; end
          default: begin read_b = 1'b0; write = 1'b1; end
        endcase
        address_b = $urandom; wdata = $urandom; wmask = 4'($urandom_range(15, 0));
      end
      mem_resp  = ($urandom_range(3, 0) == 0);
      mem_rdata = $urandom;
      if ($urandom_range(299, 0) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
    end
    apply_stimulus_idle();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
